id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/pipeline_pkg.sv | 51 +++++
 rtl/regfile.sv | 38 +++
 rtl/id_stage.sv | 105 ++++++++++
 tb/tb_id_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared decode definitions for the pipeline: opcodes, ALU operation classes,
// the control bundle and the opcode-to-control decode helpers.
package pipeline_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RFUNCT = 2'b10,
        ALU_IFUNCT = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        aluop_e aluop;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_R:      c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_RFUNCT};
            OP_I:      c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALU_IFUNCT};
            OP_LOAD:   c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD};
            OP_STORE:  c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD};
            OP_BRANCH: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_BRANCH};
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // Only these formats actually read rs2, so only they can hazard on rt
    function automatic logic uses_rt(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, one write port, x0 fixed at 0.
// Define ID_WB_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
        rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
`ifdef ID_WB_BYPASS_EN
        if (rst && we_i && (wa_i != 5'd0) && (wa_i == ra1_i)) rd1_o = wd_i;
        if (rst && we_i && (wa_i != 5'd0) && (wa_i == ra2_i)) rd2_o = wd_i;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field/control/immediate decode, load-use stall,
// sticky illegal flag and saturating stall counter. ID_WB_BYPASS_EN selects regfile write-through.
module id_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        valid_in,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    output logic        AluSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  Aluop,
    output logic [31:0] rs1Data,
    output logic [31:0] rs2Data,
    output logic [31:0] immediate,
    output logic [31:0] pc_out,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic        stall,
    output logic        illegal,
    output logic [15:0] stall_cnt
);

    logic [6:0]  opcode;
    ctrl_t       ctrl_dec;
    ctrl_t       ctrl_out;
    logic        illegal_q, illegal_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        unused_funct3;

    assign opcode        = instr_in[6:0];
    assign rs            = instr_in[19:15];
    assign rt            = instr_in[24:20];
    assign rd            = instr_in[11:7];
    assign pc_out        = pc_in;
    assign unused_funct3 = ^instr_in[14:12];

    assign stall = valid_in && ex_memread && (ex_rd != 5'd0) &&
                   ((ex_rd == rs) || ((ex_rd == rt) && uses_rt(opcode)));

    assign ctrl_dec = decode_ctrl(opcode);
    assign ctrl_out = (stall || !valid_in) ? ctrl_t'('0) : ctrl_dec;

    assign AluSrc   = ctrl_out.alu_src;
    assign MemtoReg = ctrl_out.mem_to_reg;
    assign RegWrite = ctrl_out.reg_write;
    assign MemRead  = ctrl_out.mem_read;
    assign MemWrite = ctrl_out.mem_write;
    assign Aluop    = ctrl_out.aluop;

    always_comb begin
        immediate = '0;
        case (opcode)
            OP_I, OP_LOAD: immediate = {{20{instr_in[31]}}, instr_in[31:20]};
            OP_STORE:      immediate = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            OP_BRANCH:     immediate = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                                        instr_in[30:25], instr_in[11:8], 1'b0};
            default:       immediate = '0;
        endcase
    end

    regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs1Data),
        .rd2_o (rs2Data),
        .we_i  (wb_we),
        .wa_i  (wb_rd),
        .wd_i  (wb_data)
    );

    always_comb begin
        illegal_d   = illegal_q | (valid_in & ~stall & ~is_legal(opcode));
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign illegal   = illegal_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed literal cases plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        valid_in = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        AluSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic [1:0]  Aluop;
    logic [31:0] rs1Data, rs2Data, immediate, pc_out;
    logic [4:0]  rs, rt, rd;
    logic        stall, illegal;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    id_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .AluSrc(AluSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Aluop(Aluop), .rs1Data(rs1Data), .rs2Data(rs2Data),
        .immediate(immediate), .pc_out(pc_out), .rs(rs), .rt(rt), .rd(rd),
        .stall(stall), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mregs [32];
    bit          m_illegal;
    int          m_cnt;

    // {AluSrc,MemtoReg,RegWrite,MemRead,MemWrite,Aluop} table rows
    function automatic logic [6:0] m_ctrl(input logic [6:0] op);
        case (op)
            7'b0110011: return 7'b0010010;
            7'b0010011: return 7'b1010011;
            7'b0000011: return 7'b1111000;
            7'b0100011: return 7'b1000100;
            7'b1100011: return 7'b0000001;
            default:    return 7'b0000000;
        endcase
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        int v;
        logic [6:0] op;
        op = ins[6:0];
        v = 0;
        if (op == 7'b0010011 || op == 7'b0000011) begin
            v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
        end else if (op == 7'b0100011) begin
            v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 4096 : 0);
        end else if (op == 7'b1100011) begin
            v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                + int'(ins[11:8]) * 2 - (ins[31] ? 8192 : 0);
        end
        return 32'(v);
    endfunction

    function automatic bit m_stall();
        logic [6:0] op;
        bit rt_used;
        op = instr_in[6:0];
        rt_used = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
        return valid_in && ex_memread && (ex_rd != 0) &&
               ((ex_rd == instr_in[19:15]) || (rt_used && ex_rd == instr_in[24:20]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (rst && wb_we && wb_rd == r) return wb_data;
`endif
        return mregs[r];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
            m_illegal = 1'b0;
            m_cnt = 0;
        end else begin
            bit hz;
            hz = m_stall();
            if (valid_in && !hz && m_ctrl(instr_in[6:0]) == 7'b0) m_illegal = 1'b1;
            if (hz && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (wb_we && wb_rd != 0) mregs[wb_rd] = wb_data;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit hz;
            logic [6:0] ec;
            hz = m_stall();
            ec = (hz || !valid_in) ? 7'b0 : m_ctrl(instr_in[6:0]);
            check("m_ctrl", {AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Aluop}, ec);
            check("m_rs1Data", rs1Data, m_read(instr_in[19:15]));
            check("m_rs2Data", rs2Data, m_read(instr_in[24:20]));
            check("m_immediate", immediate, m_imm(instr_in));
            check("m_pc_out", pc_out, pc_in);
            check("m_fields", {rs, rt, rd}, {instr_in[19:15], instr_in[24:20], instr_in[11:7]});
            check("m_stall", stall, hz);
            check("m_illegal", illegal, m_illegal);
            check("m_stall_cnt", stall_cnt, 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ctrl_chk(input string name, input logic [6:0] exp);
        #1 check(name, {AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Aluop}, exp);
    endtask

    initial begin
        logic [31:0] ins;
        logic [6:0]  ops [6];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1111111;

        // reset with a write pending to x5
        rst = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFEF00D;
        cmp_en = 1'b1;
        step(); step();
        rst = 1'b1; wb_we = 1'b0;
        instr_in = 32'h00028033; valid_in = 1'b1; pc_in = 32'h100;
        #1;
        check("rst_x5", rs1Data, 32'h0);
        check("rst_illegal", illegal, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);

        // writeback then read: add x1,x7,x0
        step();
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF; valid_in = 1'b0;
        step();
        wb_we = 1'b0; instr_in = 32'h000380B3; valid_in = 1'b1;
        #1;
        check("wb_rs1Data", rs1Data, 32'hDEADBEEF);
        check("wb_RegWrite", RegWrite, 32'h1);
        check("wb_Aluop", Aluop, 32'h2);
        step();
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF; instr_in = 32'h00000033;
        step();
        wb_we = 1'b0;
        #1 check("x0_zero", rs1Data, 32'h0);

        // same-cycle write and read of x3
        step();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h12345678; instr_in = 32'h00018033;
        #1;
`ifdef ID_WB_BYPASS_EN
        check("bypass_x3", rs1Data, 32'h12345678);
`else
        check("bypass_x3", rs1Data, 32'h0);
`endif
        step();
        wb_we = 1'b0;
        #1 check("x3_next", rs1Data, 32'h12345678);

        // load-use on sw x4,8(x2)
        step();
        ex_memread = 1'b1; ex_rd = 5'd4; instr_in = 32'h00412423;
        #1 check("lu_stall", stall, 32'h1);
        ctrl_chk("lu_ctrl", 7'b0);
        check("lu_imm", immediate, 32'h8);
        step();
        #1 check("lu_cnt", stall_cnt, 32'h1);
        ex_rd = 5'd0;
        #1 check("lu_nostall", stall, 32'h0);
        ctrl_chk("sw_ctrl", 7'b1000100);
        ex_memread = 1'b0;

        // immediates
        step();
        instr_in = 32'hFFC0A283;
        #1 check("lw_imm", immediate, 32'hFFFFFFFC);
        check("lw_memread", {MemRead, MemtoReg}, 32'h3);
        step();
        instr_in = 32'hFE208EE3;
        #1 check("beq_imm", immediate, 32'hFFFFFFFC);
        check("beq_aluop", Aluop, 32'h1);

        // illegal opcode, sticky
        step();
        instr_in = 32'h0000007F;
        ctrl_chk("ill_ctrl", 7'b0);
        step();
        instr_in = 32'h00000033;
        #1 check("ill_set", illegal, 32'h1);
        step();
        #1 check("ill_sticky", illegal, 32'h1);

        // saturation: 65540 stalled cycles
        ex_memread = 1'b1; ex_rd = 5'd4; instr_in = 32'h00412423; valid_in = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        #1 check("sat_cnt", stall_cnt, 32'hFFFF);
        ex_memread = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 299) != 0);
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 5)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            instr_in = ins;
            pc_in = $urandom;
            valid_in = ($urandom_range(0, 4) != 0);
            wb_we = $urandom_range(0, 1);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            ex_memread = $urandom_range(0, 1);
            ex_rd = 5'($urandom_range(0, 7));
        end
        step();
        rst = 1'b1;
        step();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
